keypad_number_entry: RTL and testbench
======================================

KEYPAD_NUMBER_ENTRY -- requirements
Module: keypad_number_entry

Interface
REQ-001 Parameter SCAN_DIV, default 262144: clock cycles each keypad column is driven during scanning.
REQ-002 Parameter DEB_CYCLES, default 1000000: consecutive stable cycles required for press and for release.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 row  input  4  keypad row lines, active-low, pulled up externally; asynchronous to clk.
REQ-006 col  output 4  keypad column drive, active-low, one-hot-low while scanning.
REQ-007 num  output 13  accumulated unsigned decimal value, 0..8191, suitable for the four-digit display driver.
REQ-008 key_valid  output 1  one-cycle pulse per accepted key press.
REQ-009 key_code  output 4  code of the accepted key; valid while key_valid=1, holds last value otherwise.
REQ-010 overflow  output 1  one-cycle pulse when a digit is rejected because the result would exceed 8191.

Function
REQ-011 row SHALL pass through a 2-flop synchroniser; all decisions use the synchronised value rs.
REQ-012 Key map (row r, column c, index 0 = bit 0): r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: 0,F,E,D; key_code = hex value of legend.
REQ-013 FSM states: SCAN, PRESS_DEB, HELD, REL_DEB.
REQ-014 SCAN: col = ~(4'b0001 << idx); idx advances 0->1->2->3->0 every SCAN_DIV cycles; rs sampled on the last cycle of each column period only.
REQ-015 SCAN -> PRESS_DEB when sampled rs != 4'hF; latch idx and lowest-index low row; col frozen on that column.
REQ-016 PRESS_DEB: counter increments while latched row bit stays low; latched row bit high -> SCAN, counter cleared, idx advances to next column.
REQ-017 PRESS_DEB -> HELD when counter reaches DEB_CYCLES; in that cycle key_valid=1, key_code driven, num updated at the same edge.
REQ-018 HELD: no further key_valid (no auto-repeat); rs == 4'hF -> REL_DEB.
REQ-019 REL_DEB: counter increments while rs == 4'hF; any low bit -> HELD, counter cleared; counter reaches DEB_CYCLES -> SCAN at next column.
REQ-020 Digit keys 0-9: candidate = num*10 + d computed at 17 bits; candidate <= 8191 -> num = candidate; else num unchanged, overflow=1 same cycle as key_valid.
REQ-021 Key C: num = 0. Key E: num = num/10 (integer truncation). Keys A, B, D, F: num unchanged, key_valid still pulses.
REQ-022 Simultaneous presses in one column: lowest row wins; presses in other columns ignored until return to SCAN.

Reset
REQ-023 rst SHALL force: state SCAN, idx 0, col 4'b1110, counters 0, num 0, key_valid 0, key_code 0, overflow 0, synchroniser flops 1.
REQ-024 rst asserted mid-debounce or mid-hold SHALL abort with no key_valid; a key still held after reset is detected as a new press.

Structure
REQ-025 Shared package SHALL hold the FSM state encoding, key-code constants (KEY_CLEAR = 4'hC, KEY_BACK = 4'hE), and NUM_MAX = 8191.
REQ-026 One sub-module: sync_2ff (parameterised width, reset value 1), instantiated for row.

Verification (SCAN_DIV=4, DEB_CYCLES=8)
REQ-027 Reset, no keys -> col cycles 1110,1101,1011,0111 each 4 cycles; num=0; no pulses.
REQ-028 Press "1","2","3" each held 20 cycles then released 20 cycles -> exactly three key_valid pulses; num 1, 12, 123.
REQ-029 Press bounce: row0 low 5 cycles, high 2, then low 20 -> one key_valid only; no pulse from the 5-cycle glitch.
REQ-030 num=819, press "2" -> num=8192 rejected: num stays 819, overflow and key_valid pulse together; press "1" -> num=8191.
REQ-031 num=123, press E -> 12; press C -> 0; press A -> key_valid with key_code 4'hA, num 0.
REQ-032 rst asserted during PRESS_DEB with key held -> no key_valid; after rst release key detected as new press, num 1 after press "1".

Source files
------------

// File: rtl/keypad_number_entry_pkg.sv
// Shared definitions for the keypad number-entry block.
//   state_t    : scanner/debounce FSM state encoding
//   NUM_W      : width of the accumulated value
//   NUM_MAX    : largest value the accumulator may hold
//   KEY_CLEAR  : key code that zeroes the value
//   KEY_BACK   : key code that drops the last decimal digit
//   key_lookup : (row, column) -> key code of the printed legend
package keypad_number_entry_pkg;

  typedef enum logic [1:0] {
    ST_SCAN      = 2'd0,
    ST_PRESS_DEB = 2'd1,
    ST_HELD      = 2'd2,
    ST_REL_DEB   = 2'd3
  } state_t;

  localparam int          NUM_W     = 13;
  localparam int unsigned NUM_MAX   = 8191;
  localparam logic [3:0]  KEY_CLEAR = 4'hC;
  localparam logic [3:0]  KEY_BACK  = 4'hE;

  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'h0;
      4'b11_01: code = 4'hF;
      4'b11_10: code = 4'hE;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_number_entry_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; both flops reset to all ones
// so idle (pulled-up) lines read as released straight out of reset.
//   clk : sampling clock
//   rst : synchronous active-high reset
//   d   : asynchronous input bus
//   q   : synchronised output bus
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0 <= '1;
      q       <= '1;
    end else begin
      // stage 0: capture, may go metastable
      meta_p0 <= d;
      // stage 1: resolved value
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/keypad_number_entry.sv
// 4x4 matrix keypad scanner with press/release debounce and a decimal
// accumulator for a four-digit display.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   row       : keypad rows, active-low, asynchronous
//   col       : keypad column drive, active-low, one low at a time
//   num       : accumulated value 0..8191
//   key_valid : one-cycle pulse per accepted press
//   key_code  : code of the last accepted key
//   overflow  : one-cycle pulse when a digit would exceed 8191
module keypad_number_entry
  import keypad_number_entry_pkg::*;
#(
  parameter int SCAN_DIV   = 262144,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  output logic [NUM_W-1:0] num,
  output logic             key_valid,
  output logic [3:0]       key_code,
  output logic             overflow
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);

  // Lowest-index low row wins when several rows in a column are pressed.
  function automatic logic [1:0] lowest_low(input logic [3:0] r);
    logic [1:0] sel;
    sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r[i]) sel = 2'(i);
    end
    return sel;
  endfunction

  // Accumulator update; digits that would push past NUM_MAX are refused.
  function automatic logic [NUM_W-1:0] apply_key(input  logic [NUM_W-1:0] cur,
                                                 input  logic [3:0]       code,
                                                 output logic             ovf);
    logic [16:0]      cand;
    logic [NUM_W-1:0] res;
    ovf  = 1'b0;
    cand = 17'(cur) * 17'd10 + 17'(code);
    if (code <= 4'd9) begin
      if (cand <= 17'(NUM_MAX)) begin
        res = cand[NUM_W-1:0];
      end else begin
        res = cur;
        ovf = 1'b1;
      end
    end else if (code == KEY_CLEAR) begin
      res = '0;
    end else if (code == KEY_BACK) begin
      res = cur / NUM_W'(10);
    end else begin
      res = cur;
    end
    return res;
  endfunction

  logic [3:0]        rs;
  state_t            state;
  logic [1:0]        idx;
  logic [1:0]        row_l;
  logic [SCAN_W-1:0] scan_cnt;
  logic [DEB_W-1:0]  deb_cnt;
  logic [3:0]        hit_code;
  logic [NUM_W-1:0]  num_next;
  logic              ovf_next;

  sync_2ff #(.WIDTH(4)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row),
    .q   (rs)
  );

  always_comb begin
    hit_code = key_lookup(row_l, idx);
    ovf_next = 1'b0;
    num_next = apply_key(num, hit_code, ovf_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SCAN;
      idx       <= 2'd0;
      col       <= 4'b1110;
      row_l     <= 2'd0;
      scan_cnt  <= '0;
      deb_cnt   <= '0;
      num       <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      overflow  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      overflow  <= 1'b0;
      case (state)
        ST_SCAN: begin
          // rows are only judged at the end of a column period, when the
          // column drive has had the whole period to settle
          if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            if (rs != 4'hF) begin
              state   <= ST_PRESS_DEB;
              row_l   <= lowest_low(rs);
              deb_cnt <= '0;
            end else begin
              idx <= idx + 2'd1;
              col <= {col[2:0], col[3]};
            end
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
        end
        ST_PRESS_DEB: begin
          if (rs[row_l]) begin
            state   <= ST_SCAN;
            deb_cnt <= '0;
            idx     <= idx + 2'd1;
            col     <= {col[2:0], col[3]};
          end else if (deb_cnt == DEB_LAST) begin
            state     <= ST_HELD;
            deb_cnt   <= '0;
            key_valid <= 1'b1;
            key_code  <= hit_code;
            num       <= num_next;
            overflow  <= ovf_next;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        ST_HELD: begin
          if (rs == 4'hF) begin
            state   <= ST_REL_DEB;
            deb_cnt <= '0;
          end
        end
        default: begin
          if (rs != 4'hF) begin
            state   <= ST_HELD;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state   <= ST_SCAN;
            deb_cnt <= '0;
            idx     <= idx + 2'd1;
            col     <= {col[2:0], col[3]};
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_number_entry.sv
// Bench for keypad_number_entry: a physical keypad matrix model answers the
// column drive, and accepted keys are checked against a decimal-entry model.
module tb_keypad_number_entry;

  localparam int SCAN_DIV   = 4;
  localparam int DEB_CYCLES = 8;
  localparam int HOLD       = 40;
  localparam int REL        = 30;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [12:0] num;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        overflow;

  always #5 clk = ~clk;

  keypad_number_entry #(.SCAN_DIV(SCAN_DIV), .DEB_CYCLES(DEB_CYCLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .num       (num),
    .key_valid (key_valid),
    .key_code  (key_code),
    .overflow  (overflow)
  );

  // Keypad matrix: a pressed switch pulls its row low only while its column is driven.
  logic pressed = 1'b0;
  int   pr = 0;
  int   pc = 0;
  always_comb begin
    row = 4'hF;
    if (pressed && !col[pc]) row[pr] = 1'b0;
  end

  logic [3:0] keymap [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                '{4'h4, 4'h5, 4'h6, 4'hB},
                                '{4'h7, 4'h8, 4'h9, 4'hC},
                                '{4'h0, 4'hF, 4'hE, 4'hD}};

  // Output monitor, sampled on the falling edge.
  int          kv_total  = 0;
  int          ovf_total = 0;
  int          ovf_alone = 0;
  logic [3:0]  kv_code   = 4'h0;
  logic [12:0] kv_num    = 13'd0;
  logic        kv_ovf    = 1'b0;
  always @(negedge clk) begin
    if (key_valid) begin
      kv_total <= kv_total + 1;
      kv_code  <= key_code;
      kv_num   <= num;
      kv_ovf   <= overflow;
    end
    if (overflow) ovf_total <= ovf_total + 1;
    if (overflow && !key_valid) ovf_alone <= ovf_alone + 1;
  end

  int checks   = 0;
  int failures = 0;
  int model_num = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Decimal entry rules applied to an integer value.
  function automatic int model_key(input int n, input int k, output bit ov);
    int r;
    ov = 1'b0;
    r  = n;
    if (k <= 9) begin
      if (n * 10 + k > 8191) ov = 1'b1;
      else r = n * 10 + k;
    end else if (k == 12) begin
      r = 0;
    end else if (k == 14) begin
      r = n / 10;
    end
    return r;
  endfunction

  task automatic locate(input logic [3:0] code);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keymap[r][c] == code) begin
          pr = r;
          pc = c;
        end
  endtask

  // Wait until column 0 has just become active (bounded).
  task automatic wait_col0_start();
    int n;
    n = 0;
    while (col != 4'b0111 && n < 40) begin cyc(1); n++; end
    while (col != 4'b1110 && n < 40) begin cyc(1); n++; end
    if (n >= 40) check("col0_wait_timeout", n, 0);
  endtask

  task automatic press_check(input string name, input logic [3:0] code,
                             input int exp_num, input bit exp_ovf);
    int k0, o0;
    k0 = kv_total;
    o0 = ovf_total;
    locate(code);
    pressed = 1'b1;
    cyc(HOLD);
    check({name, "_pulses"}, kv_total - k0, 1);
    check({name, "_code"}, kv_code, code);
    check({name, "_num"}, kv_num, exp_num);
    check({name, "_ovf_flag"}, kv_ovf, exp_ovf);
    check({name, "_ovf_pulses"}, ovf_total - o0, exp_ovf);
    pressed = 1'b0;
    cyc(REL);
    check({name, "_no_repeat"}, kv_total - k0, 1);
    check({name, "_num_hold"}, num, exp_num);
  endtask

  typedef struct {
    logic [3:0] key;
    int         exp_num;
    bit         exp_ovf;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int         k0;
    bit         ov;
    int         nn;
    logic [3:0] e;
    logic [3:0] rk;

    tbl[0]  = '{4'h1, 1,    1'b0};
    tbl[1]  = '{4'h2, 12,   1'b0};
    tbl[2]  = '{4'h3, 123,  1'b0};
    tbl[3]  = '{4'hE, 12,   1'b0};
    tbl[4]  = '{4'hC, 0,    1'b0};
    tbl[5]  = '{4'hA, 0,    1'b0};
    tbl[6]  = '{4'h8, 8,    1'b0};
    tbl[7]  = '{4'h1, 81,   1'b0};
    tbl[8]  = '{4'h9, 819,  1'b0};
    tbl[9]  = '{4'h2, 819,  1'b1};
    tbl[10] = '{4'h1, 8191, 1'b0};
    tbl[11] = '{4'h0, 8191, 1'b1};
    tbl[12] = '{4'hE, 819,  1'b0};
    tbl[13] = '{4'hC, 0,    1'b0};

    rst = 1'b1;
    cyc(3);
    rst = 1'b0;

    // reset state and idle column scan
    check("rst_num", num, 0);
    check("rst_key_code", key_code, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_overflow", overflow, 0);
    for (int i = 0; i < 16; i++) begin
      e = ~(4'b0001 << (i / 4));
      check($sformatf("idle_col_%0d", i), col, e);
      cyc(1);
    end
    cyc(20);
    check("idle_no_pulses", kv_total, 0);
    check("idle_num", num, 0);

    // table-driven key sequence
    for (int i = 0; i < 14; i++) begin
      press_check($sformatf("tbl%0d", i), tbl[i].key, tbl[i].exp_num, tbl[i].exp_ovf);
    end
    model_num = 0;

    // press bounce: short glitch, brief release, then a real press
    wait_col0_start();
    k0 = kv_total;
    locate(4'h1);
    pressed = 1'b1; cyc(5);
    pressed = 1'b0; cyc(2);
    pressed = 1'b1; cyc(HOLD);
    pressed = 1'b0; cyc(REL);
    model_num = model_key(model_num, 1, ov);
    check("bounce_pulses", kv_total - k0, 1);
    check("bounce_num", num, model_num);

    // reset during press debounce
    wait_col0_start();
    k0 = kv_total;
    locate(4'h1);
    pressed = 1'b1;
    cyc(6);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    check("rstdeb_no_pulse", kv_total - k0, 0);
    check("rstdeb_num_cleared", num, 0);
    cyc(HOLD);
    check("rstdeb_new_press", kv_total - k0, 1);
    check("rstdeb_code", kv_code, 1);
    check("rstdeb_num", num, 1);
    pressed = 1'b0;
    cyc(REL);
    model_num = 1;

    // randomized keys against the entry model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0) rk = 4'($urandom_range(0, 9));
      else rk = 4'($urandom_range(0, 15));
      nn = model_key(model_num, int'(rk), ov);
      press_check($sformatf("rnd%0d", i), rk, nn, ov);
      model_num = nn;
    end

    check("overflow_without_key", ovf_alone, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
